// File: rtl/sc_dmem_arbiter.sv
// Shared data-memory arbiter between a CPU port and a DMA master, with optional burst lock.
// Define DMEM_ARB_STARVE_EN to compile in the DMA starvation counter (forced grant at STARVE_LIMIT).
module sc_dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clock,
  input  logic        resetn,
  // CPU port
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  // DMA port
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic        dma_lock,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  // Shared memory
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  owner
);

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StCpu     = 2'b01,
    StDma     = 2'b10,
    StDmaLock = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    GntNone = 2'b00,
    GntCpu  = 2'b01,
    GntDma  = 2'b10
  } grant_e;

  state_e state_q, state_d;
  grant_e grant;
  logic   force_dma;
  logic   rvalid_q, rvalid_d;

`ifdef DMEM_ARB_STARVE_EN
  // +2 keeps the width non-zero and leaves room to hold STARVE_LIMIT itself.
  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 2);
  localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

  logic [CntW-1:0] starve_q, starve_d;

  always_comb begin
    starve_d = starve_q;
    if (!dma_req || grant == GntDma) begin
      starve_d = '0;
    end else if (grant == GntCpu && starve_q < Limit) begin
      starve_d = starve_q + CntW'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign force_dma = (starve_q >= Limit);
`else
  // Without the counter the limit has no effect; CPU keeps strict priority.
  assign force_dma = 1'b0 & (STARVE_LIMIT > 0);
`endif

  // State register: records the previous cycle's grant.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic, including the per-cycle priority grant.
  always_comb begin
    grant = GntNone;
    if (!resetn) begin
      grant = GntNone;
    end else if (state_q == StDmaLock && dma_req) begin
      grant = GntDma;
    end else if (force_dma && dma_req) begin
      grant = GntDma;
    end else if (cpu_req) begin
      grant = GntCpu;
    end else if (dma_req) begin
      grant = GntDma;
    end

    state_d = StIdle;
    unique case (grant)
      GntDma:  state_d = dma_lock ? StDmaLock : StDma;
      GntCpu:  state_d = StCpu;
      default: state_d = StIdle;
    endcase
  end

  // Output logic: memory mux and port handshakes.
  always_comb begin
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_we    = 1'b0;
    unique case (grant)
      GntCpu: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we;
      end
      GntDma: begin
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        mem_we    = dma_we;
      end
      default: ;
    endcase

    cpu_stall = cpu_req && (grant != GntCpu);
    dma_gnt   = (grant == GntDma);
    owner     = grant;
  end

  // Memory returns read data one cycle after issue; flag it for the DMA side.
  assign rvalid_d = (grant == GntDma) && !dma_we;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rvalid_d;
    end
  end

  assign dma_rvalid = rvalid_q;
  assign dma_rdata  = rvalid_q ? mem_rdata : 32'h0;
  assign cpu_rdata  = mem_rdata;

endmodule

// File: tb/tb_sc_dmem_arbiter.sv
// Self-checking bench for sc_dmem_arbiter: memory model plus a queue of expected DMA read data.
module tb_sc_dmem_arbiter;

`ifdef DMEM_ARB_STARVE_EN
  localparam bit StarveEn = 1'b1;
  localparam int StarveCycles = 10;
`else
  localparam bit StarveEn = 1'b0;
  localparam int StarveCycles = 100;
`endif

  logic        clock = 1'b0;
  logic        resetn;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_req, dma_we, dma_lock;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_gnt, dma_rvalid;
  logic [31:0] dma_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [1:0]  owner;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem [0:255];

  sc_dmem_arbiter #(.STARVE_LIMIT(8)) dut (
    .clock(clock), .resetn(resetn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .owner(owner)
  );

  always #5 clock = ~clock;

  // Synchronous memory: read data appears the cycle after the address.
  always @(posedge clock) begin
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[9:2]];
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_lock = 0; dma_addr = 0; dma_wdata = 0;
  endtask

  task automatic test_reset();
    resetn = 0;
    idle_inputs();
    tick(); tick();
    #2;
    total++; if (owner !== 2'b00) begin bad++; $display("FAIL rst_owner: got %b want 00", owner); end
    total++; if (dma_gnt !== 1'b0) begin bad++; $display("FAIL rst_gnt: got %b want 0", dma_gnt); end
    total++; if (dma_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid: got %b want 0", dma_rvalid); end
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", cpu_stall); end
    total++; if (dma_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", dma_rdata); end
    // Requests during reset must not reach memory.
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h30; dma_req = 1; dma_we = 1;
    #1;
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_memwe: got %b want 0", mem_we); end
    total++; if (owner !== 2'b00) begin bad++; $display("FAIL rst_owner_req: got %b want 00", owner); end
    total++; if (dma_gnt !== 1'b0) begin bad++; $display("FAIL rst_gnt_req: got %b want 0", dma_gnt); end
    tick();
    idle_inputs();
    resetn = 1;
    tick();
  endtask

  task automatic test_cpu_write();
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'h1234_5678;
    #3;
    total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL cw_we: got %b want 1", mem_we); end
    total++; if (mem_addr !== 32'h20) begin bad++; $display("FAIL cw_addr: got %h want 20", mem_addr); end
    total++; if (mem_wdata !== 32'h1234_5678) begin bad++; $display("FAIL cw_wdata: got %h want 12345678", mem_wdata); end
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL cw_stall: got %b want 0", cpu_stall); end
    total++; if (owner !== 2'b01) begin bad++; $display("FAIL cw_owner: got %b want 01", owner); end
    tick();
    idle_inputs();
    #3;
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL idle_we: got %b want 0", mem_we); end
    total++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0)
      begin bad++; $display("FAIL idle_bus: got %h/%h want 0/0", mem_addr, mem_wdata); end
    total++; if (owner !== 2'b00) begin bad++; $display("FAIL idle_owner: got %b want 00", owner); end
    tick();
  endtask

  task automatic test_dma_read();
    dma_req = 1; dma_we = 1; dma_addr = 32'h10; dma_wdata = 32'hDEAD_BEEF;
    #3;
    total++; if (dma_gnt !== 1'b1 || mem_we !== 1'b1 || owner !== 2'b10)
      begin bad++; $display("FAIL dw_gnt: got gnt=%b we=%b own=%b want 1/1/10", dma_gnt, mem_we, owner); end
    tick();
    dma_we = 0;
    #3;
    total++; if (dma_gnt !== 1'b1) begin bad++; $display("FAIL dr_gnt: got %b want 1", dma_gnt); end
    total++; if (dma_rvalid !== 1'b0 || dma_rdata !== 32'h0)
      begin bad++; $display("FAIL dr_after_write: got %b/%h want 0/0", dma_rvalid, dma_rdata); end
    exp_q.push_back(32'hDEAD_BEEF);
    tick();
    idle_inputs();
    #3;
    total++;
    if (dma_rvalid !== 1'b1) begin
      bad++; $display("FAIL dr_rvalid: got %b want 1", dma_rvalid);
    end else begin
      automatic logic [31:0] e = exp_q.pop_front();
      if (dma_rdata !== e) begin bad++; $display("FAIL dr_rdata: got %h want %h", dma_rdata, e); end
      total++; if (cpu_rdata !== e) begin bad++; $display("FAIL cpu_rdata: got %h want %h", cpu_rdata, e); end
    end
    tick();
    #3;
    total++; if (dma_rvalid !== 1'b0) begin bad++; $display("FAIL dr_single: got %b want 0", dma_rvalid); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] datas [3];
    addrs[0] = 32'h10; addrs[1] = 32'h20; addrs[2] = 32'h10;
    datas[0] = 32'hDEAD_BEEF; datas[1] = 32'h1234_5678; datas[2] = 32'hDEAD_BEEF;
    for (int i = 0; i < 6; i++) begin
      idle_inputs();
      if (i < 3) begin
        dma_req = 1; dma_we = 0; dma_addr = addrs[i];
      end else if (i == 3) begin
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20;
      end
      #3;
      if (i < 3) begin
        total++; if (dma_gnt !== 1'b1) begin bad++; $display("FAIL b2b_gnt%0d: got %b want 1", i, dma_gnt); end
        exp_q.push_back(datas[i]);
      end
      if (i == 3) begin
        total++; if (owner !== 2'b01 || cpu_stall !== 1'b0)
          begin bad++; $display("FAIL b2b_cpu: got own=%b stall=%b want 01/0", owner, cpu_stall); end
      end
      if (i == 4) begin
        total++; if (cpu_rdata !== 32'h1234_5678)
          begin bad++; $display("FAIL b2b_cpu_rdata: got %h want 12345678", cpu_rdata); end
      end
      total++;
      if (dma_rvalid !== (i >= 1 && i <= 3)) begin
        bad++; $display("FAIL b2b_rvalid%0d: got %b want %b", i, dma_rvalid, (i >= 1 && i <= 3));
      end
      if (dma_rvalid === 1'b1 && exp_q.size() > 0) begin
        automatic logic [31:0] e = exp_q.pop_front();
        total++; if (dma_rdata !== e) begin bad++; $display("FAIL b2b_rdata%0d: got %h want %h", i, dma_rdata, e); end
      end
      tick();
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_left: got %0d want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_lock();
    idle_inputs();
    dma_req = 1; dma_we = 1; dma_lock = 1; dma_addr = 32'h40;
    #3;
    total++; if (dma_gnt !== 1'b1) begin bad++; $display("FAIL lk_first: got %b want 1", dma_gnt); end
    tick();
    for (int k = 0; k < 4; k++) begin
      cpu_req = 1; cpu_addr = 32'h20; dma_addr = 32'h44 + 32'(k);
      #3;
      total++; if (dma_gnt !== 1'b1 || cpu_stall !== 1'b1 || owner !== 2'b10)
        begin bad++; $display("FAIL lk_hold%0d: got gnt=%b stall=%b own=%b want 1/1/10", k, dma_gnt, cpu_stall, owner); end
      tick();
    end
    dma_req = 0;
    #3;
    total++; if (owner !== 2'b01 || cpu_stall !== 1'b0 || dma_gnt !== 1'b0)
      begin bad++; $display("FAIL lk_release: got own=%b stall=%b gnt=%b want 01/0/0", owner, cpu_stall, dma_gnt); end
    tick();
    // Lock dropped with dma_req still high: one more DMA beat, then CPU wins.
    cpu_req = 0; dma_req = 1; dma_lock = 1;
    tick();
    cpu_req = 1; dma_lock = 0;
    #3;
    total++; if (dma_gnt !== 1'b1) begin bad++; $display("FAIL lk_drop_beat: got %b want 1", dma_gnt); end
    tick();
    #3;
    total++; if (dma_gnt !== 1'b0 || owner !== 2'b01)
      begin bad++; $display("FAIL lk_drop_exit: got gnt=%b own=%b want 0/01", dma_gnt, owner); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_starve();
    for (int c = 0; c < StarveCycles; c++) begin
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20;
      dma_req = 1; dma_we = 1; dma_lock = 0; dma_addr = 32'h48;
      #3;
      total++;
      if (dma_gnt !== (StarveEn && c == 8) || cpu_stall !== (StarveEn && c == 8)) begin
        bad++;
        $display("FAIL starve_c%0d: got gnt=%b stall=%b want %b/%b", c, dma_gnt, cpu_stall,
                 (StarveEn && c == 8), (StarveEn && c == 8));
      end
      if (c == 9) begin
        total++; if (owner !== 2'b01) begin bad++; $display("FAIL starve_regrant: got %b want 01", owner); end
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_midread();
    idle_inputs();
    dma_req = 1; dma_we = 0; dma_lock = 1; dma_addr = 32'h10;
    #3;
    total++; if (dma_gnt !== 1'b1) begin bad++; $display("FAIL mr_gnt: got %b want 1", dma_gnt); end
    exp_q.push_back(32'hDEAD_BEEF);
    tick();
    total++; if (dma_rvalid !== 1'b1) begin bad++; $display("FAIL mr_pending: got %b want 1", dma_rvalid); end
    resetn = 0;
    #1;
    total++; if (dma_rvalid !== 1'b0 || dma_rdata !== 32'h0)
      begin bad++; $display("FAIL mr_async: got %b/%h want 0/0", dma_rvalid, dma_rdata); end
    total++; if (dma_gnt !== 1'b0 || owner !== 2'b00)
      begin bad++; $display("FAIL mr_rst_gnt: got %b/%b want 0/00", dma_gnt, owner); end
    exp_q.delete();
    tick();
    resetn = 1;
    // Lock state must be gone: CPU wins over a locked DMA request.
    cpu_req = 1; dma_req = 1; dma_lock = 1; dma_we = 1;
    #3;
    total++; if (owner !== 2'b01 || dma_rvalid !== 1'b0)
      begin bad++; $display("FAIL mr_post: got own=%b rv=%b want 01/0", owner, dma_rvalid); end
    tick();
    idle_inputs();
    #3;
    total++; if (dma_rvalid !== 1'b0) begin bad++; $display("FAIL mr_no_rvalid: got %b want 0", dma_rvalid); end
    tick();
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_dma_read();
    test_back_to_back();
    test_lock();
    test_starve();
    test_reset_midread();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
